l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Shares the single L2 cache port between the L1 instruction cache and the L1 data cache.
- Sits between the two L1 controllers and the L2 cache controller.
- Round-robin grant, held for a whole transaction, locked until L2 response or requester abort.
- Routes address, write data and control downstream; routes read data and response back to the granted requester only.

Parameters:
- ADDR_WIDTH, 32, byte address width of all ports.
- LINE_WIDTH, 256, cache line data width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_mem_read  in  1  I-cache read request, held until i_mem_resp.
- i_mem_write  in  1  I-cache write request, held until i_mem_resp.
- i_mem_address  in  ADDR_WIDTH  I-cache line address.
- i_mem_wdata  in  LINE_WIDTH  I-cache write line.
- i_mem_rdata  out  LINE_WIDTH  read line to I-cache.
- i_mem_resp  out  1  completion pulse to I-cache.
- d_mem_read  in  1  D-cache read request, held until d_mem_resp.
- d_mem_write  in  1  D-cache write request, held until d_mem_resp.
- d_mem_address  in  ADDR_WIDTH  D-cache line address.
- d_mem_wdata  in  LINE_WIDTH  D-cache write line.
- d_mem_rdata  out  LINE_WIDTH  read line to D-cache.
- d_mem_resp  out  1  completion pulse to D-cache.
- l2_mem_read  out  1  read request to L2.
- l2_mem_write  out  1  write request to L2.
- l2_mem_address  out  ADDR_WIDTH  address to L2.
- l2_mem_wdata  out  LINE_WIDTH  write line to L2.
- l2_mem_rdata  in  LINE_WIDTH  read line from L2.
- l2_mem_resp  in  1  L2 completion.

Behaviour:
- State register: IDLE, SERVE_I, SERVE_D.
- Priority register: last_grant (I/D).
- Async reset sets state=IDLE and last_grant=D, so I wins the first tie.
- Reset outputs: all l2_* controls 0, both *_resp 0, l2_mem_address/wdata 0, both *_rdata 0.
- Request definition: req_x = x_mem_read | x_mem_write.
- IDLE:
  - All l2_* control outputs are 0.
  - Only one requester active: go to its SERVE state.
  - Both active: grant the one not equal to last_grant.
  - Neither active: stay.
  - Grant takes effect next cycle, so downstream request appears 1 cycle after upstream request.
- SERVE_x:
  - l2_mem_read/write/address/wdata = x's signals (combinational mux on registered state).
  - x_mem_rdata = l2_mem_rdata; x_mem_resp = l2_mem_resp.
  - The non-granted requester sees resp=0 and rdata=0.
- SERVE_x exit on l2_mem_resp=1: go to IDLE and set last_grant=x. The resp pulse is passed through in the same cycle.
- SERVE_x exit on abort: if req_x drops without resp, go to IDLE and leave last_grant unchanged. The L2 controller returns to its check state when its request drops, so no response is owed.
- Mandatory IDLE cycle: at least one IDLE cycle between grants, so L2 sees its request deassert after every response.
- Back-to-back same requester: the next transaction still takes the IDLE cycle. Round-robin applies only on a tie.
- Read and write both asserted by one requester: forwarded unchanged. Checking this is the requester's responsibility.
- Starvation bound: with both requesting continuously, grants alternate strictly I, D, I, D.
- Reset mid-transaction: immediately returns to IDLE with all outputs 0. An in-flight L2 response after reset is ignored, since IDLE drops resp.

Decomposition:
- Shared package l2_arb_pkg:
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D}.
  - enum requester_t {REQ_I, REQ_D}.
  - Parameters ADDR_WIDTH and LINE_WIDTH defaults.
- Sub-module rr_pick_2: combinational 2-way round-robin chooser. Inputs req_i, req_d, last_grant; output grant and valid. Reusable for a future writeback-buffer port.
- The FSM and muxes stay in l2_arbiter.

Test Plan:
- Single I read: i_mem_read=1, addr 0x100 at cycle 0.
  - Cycle 1: l2_mem_read=1, l2_mem_address=0x100.
  - L2 resp at cycle 5 with rdata=0xA5..A5: i_mem_resp=1 and i_mem_rdata=0xA5..A5 at cycle 5; d_mem_resp=0.
  - Cycle 6: state IDLE.
- Simultaneous I and D requests after reset: I granted first.
  - After I's resp: one IDLE cycle with l2 controls 0, then D's address (0x200) on l2_mem_address.
  - d_mem_write forwarded with wdata intact.
- Continuous contention for 6 transactions: grant order is exactly I, D, I, D, I, D, each separated by one IDLE cycle.
- Abort: D requests and is granted; d_mem_read drops at cycle 3 with no resp.
  - Cycle 4: IDLE, l2_mem_read=0.
  - last_grant unchanged, so I wins the next tie.
- Reset asserted mid-SERVE_D, asynchronously between clock edges: all outputs 0 immediately.
  - A later l2_mem_resp=1 produces no *_mem_resp.
- Isolation: during SERVE_I, toggle d_mem_address and d_mem_wdata every cycle.
  - l2_mem_address and l2_mem_wdata track only I's values.
  - d_mem_rdata stays 0.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L1-to-L2 port arbiter.
package l2_arb_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin chooser: on a tie, the requester that was not granted last wins.
module rr_pick_2
  import l2_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  requester_t last_grant,
  output requester_t grant,
  output logic       valid
);

  always_comb begin
    grant = REQ_I;
    valid = req_i | req_d;
    if (req_i && req_d) begin
      grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      grant = REQ_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and D-cache; one transaction
// is granted at a time and held until the L2 responds or the requester drops.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH = DEFAULT_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic [LINE_WIDTH-1:0] i_mem_wdata,
  output logic [LINE_WIDTH-1:0] i_mem_rdata,
  output logic                  i_mem_resp,

  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_wdata,
  output logic [LINE_WIDTH-1:0] d_mem_rdata,
  output logic                  d_mem_resp,

  output logic                  l2_mem_read,
  output logic                  l2_mem_write,
  output logic [ADDR_WIDTH-1:0] l2_mem_address,
  output logic [LINE_WIDTH-1:0] l2_mem_wdata,
  input  logic [LINE_WIDTH-1:0] l2_mem_rdata,
  input  logic                  l2_mem_resp
);

  arb_state_t state;
  requester_t last_grant;
  requester_t pick;
  logic       pick_valid;
  logic       req_i;
  logic       req_d;

  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;

  rr_pick_2 u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  // Every exit from a SERVE state passes through IDLE, so the L2 always sees
  // its request drop between transactions. Aborts keep the old priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_D;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= (pick == REQ_I) ? SERVE_I : SERVE_D;
          end
        end
        SERVE_I: begin
          if (l2_mem_resp) begin
            state      <= IDLE;
            last_grant <= REQ_I;
          end else if (!req_i) begin
            state <= IDLE;
          end
        end
        SERVE_D: begin
          if (l2_mem_resp) begin
            state      <= IDLE;
            last_grant <= REQ_D;
          end else if (!req_d) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath mux keyed on the registered grant; the idle side sees zeros.
  always_comb begin
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    l2_mem_address = '0;
    l2_mem_wdata   = '0;
    i_mem_rdata    = '0;
    i_mem_resp     = 1'b0;
    d_mem_rdata    = '0;
    d_mem_resp     = 1'b0;
    case (state)
      SERVE_I: begin
        l2_mem_read    = i_mem_read;
        l2_mem_write   = i_mem_write;
        l2_mem_address = i_mem_address;
        l2_mem_wdata   = i_mem_wdata;
        i_mem_rdata    = l2_mem_rdata;
        i_mem_resp     = l2_mem_resp;
      end
      SERVE_D: begin
        l2_mem_read    = d_mem_read;
        l2_mem_write   = d_mem_write;
        l2_mem_address = d_mem_address;
        l2_mem_wdata   = d_mem_wdata;
        d_mem_rdata    = l2_mem_rdata;
        d_mem_resp     = l2_mem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: requester drivers push expected responses,
// a negedge monitor pops and compares, and a behavioural L2 memory answers.
module tb_l2_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int TIMEOUT = 60;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_address, d_mem_address;
  logic [LW-1:0] i_mem_wdata, d_mem_wdata;
  logic [LW-1:0] i_mem_rdata, d_mem_rdata;
  logic          i_mem_resp, d_mem_resp;
  logic          l2_mem_read, l2_mem_write;
  logic [AW-1:0] l2_mem_address;
  logic [LW-1:0] l2_mem_wdata;
  logic [LW-1:0] l2_mem_rdata;
  logic          l2_mem_resp;

  int errors = 0;
  int checks = 0;

  // L2 model controls
  bit l2_auto = 1'b1;
  bit l2_lat_rand = 1'b0;
  int l2_lat = 2;
  bit manual_resp = 1'b0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          owner_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            gap;
  } gnt_t;

  exp_t qi[$];
  exp_t qd[$];
  gnt_t glog[$];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  logic [LW-1:0] l2_mem  [logic [AW-1:0]];

  l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_mem_read     (i_mem_read),
    .i_mem_write    (i_mem_write),
    .i_mem_address  (i_mem_address),
    .i_mem_wdata    (i_mem_wdata),
    .i_mem_rdata    (i_mem_rdata),
    .i_mem_resp     (i_mem_resp),
    .d_mem_read     (d_mem_read),
    .d_mem_write    (d_mem_write),
    .d_mem_address  (d_mem_address),
    .d_mem_wdata    (d_mem_wdata),
    .d_mem_rdata    (d_mem_rdata),
    .d_mem_resp     (d_mem_resp),
    .l2_mem_read    (l2_mem_read),
    .l2_mem_write   (l2_mem_write),
    .l2_mem_address (l2_mem_address),
    .l2_mem_wdata   (l2_mem_wdata),
    .l2_mem_rdata   (l2_mem_rdata),
    .l2_mem_resp    (l2_mem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h5a5a_0000}};
  endfunction

  function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [LW-1:0] l2_read(input logic [AW-1:0] a);
    return l2_mem.exists(a) ? l2_mem[a] : init_line(a);
  endfunction

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input bit is_d, input logic [LW-1:0] rd);
    exp_t e;
    checks++;
    if ((is_d && qd.size() == 0) || (!is_d && qi.size() == 0)) begin
      errors++;
      $display("FAIL %s_resp_unexpected: got resp=1 expected 0 (t=%0t)", is_d ? "d" : "i", $time);
      return;
    end
    e = is_d ? qd.pop_front() : qi.pop_front();
    if (!e.wr) chk_v(is_d ? "d_rdata" : "i_rdata", rd, e.rdata);
  endtask

  // One requester transaction; abort_cyc>0 drops the request after that many cycles.
  task automatic txn(input bit is_d, input bit wr, input logic [AW-1:0] a,
                     input logic [LW-1:0] wd, input int abort_cyc);
    exp_t e;
    int   n;
    bit   got;
    if (abort_cyc == 0) begin
      e.wr    = wr;
      e.addr  = a;
      e.rdata = wr ? '0 : ref_read(a);
      if (wr) ref_mem[a] = wd;
      if (is_d) qd.push_back(e);
      else      qi.push_back(e);
    end
    if (is_d) begin
      d_mem_read = !wr; d_mem_write = wr; d_mem_address = a; d_mem_wdata = wd;
    end else begin
      i_mem_read = !wr; i_mem_write = wr; i_mem_address = a; i_mem_wdata = wd;
    end
    n = 0;
    got = 1'b0;
    while (!got) begin
      @(negedge clk);
      got = is_d ? d_mem_resp : i_mem_resp;
      n++;
      if (!got && abort_cyc != 0 && n >= abort_cyc) break;
      if (!got && n >= TIMEOUT) begin
        errors++;
        checks++;
        $display("FAIL %s_timeout: got no resp after %0d cycles expected resp", is_d ? "d" : "i", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (is_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
    else      begin i_mem_read = 1'b0; i_mem_write = 1'b0; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_address = '0; i_mem_wdata = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Behavioural L2: answers after a latency, commits writes only on response.
  initial begin : l2_model
    int cnt;
    int lat;
    cnt = 0;
    lat = 1;
    l2_mem_resp = 1'b0;
    l2_mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      l2_mem_rdata = {8{$urandom}};
      if (!l2_auto) begin
        l2_mem_resp = manual_resp;
        cnt = 0;
      end else begin
        l2_mem_resp = 1'b0;
        if (reset || !(l2_mem_read || l2_mem_write)) begin
          cnt = 0;
        end else begin
          if (cnt == 0) lat = l2_lat_rand ? int'($urandom_range(1, 4)) : l2_lat;
          cnt++;
          if (cnt >= lat) begin
            if (l2_mem_write) l2_mem[l2_mem_address] = l2_mem_wdata;
            else              l2_mem_rdata = l2_read(l2_mem_address);
            l2_mem_resp = 1'b1;
            cnt = 0;
          end
        end
      end
    end
  end

  // Monitor: scoreboard pops, post-response idle check, grant log.
  int   cyc = 0;
  int   last_resp_cyc = -100;
  logic prev_req = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin : mon
    logic cur_req;
    cyc++;
    cur_req = l2_mem_read | l2_mem_write;
    if (i_mem_resp) sb_pop(1'b0, i_mem_rdata);
    if (d_mem_resp) sb_pop(1'b1, d_mem_rdata);
    if (prev_done) chk_b("idle_after_resp", cur_req, 1'b0);
    if (cur_req && !prev_req)
      glog.push_back('{owner_d: l2_mem_address[9], wr: l2_mem_write, addr: l2_mem_address,
                       wdata: l2_mem_wdata, gap: cyc - last_resp_cyc});
    if (l2_mem_resp && cur_req) last_resp_cyc = cyc;
    prev_done = l2_mem_resp && cur_req && !reset;
    prev_req = cur_req;
  end

  // Abort by D, then a tie; winner follows the priority left by the prior completed owner.
  task automatic abort_then_tie(input bit prior_d);
    logic [AW-1:0] win_addr;
    do_reset();
    l2_lat = 2;
    txn(prior_d, 1'b0, prior_d ? 32'h2A0 : 32'h1A0, '0, 0);
    l2_lat = 10;
    txn(1'b1, 1'b0, 32'h240, '0, 3);
    @(negedge clk);
    chk_b("abort_l2_read_drop", l2_mem_read, 1'b0);
    @(posedge clk);
    #1;
    l2_lat = 2;
    win_addr = prior_d ? 32'h180 : 32'h280;
    fork
      txn(1'b0, 1'b0, 32'h180, '0, 0);
      txn(1'b1, 1'b0, 32'h280, '0, 0);
      begin
        @(negedge clk);
        chk_b("abort_idle_cycle", l2_mem_read, 1'b0);
        @(negedge clk);
        chk_v("abort_tie_winner", LW'(l2_mem_address), LW'(win_addr));
      end
    join
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [LW-1:0] wd;
    reset = 1'b1;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_address = '0; i_mem_wdata = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    l2_mem[32'h100] = {32{8'hA5}};
    ref_mem[32'h100] = {32{8'hA5}};

    // reset state
    repeat (2) @(negedge clk);
    chk_b("rst_l2_read", l2_mem_read, 1'b0);
    chk_b("rst_l2_write", l2_mem_write, 1'b0);
    chk_v("rst_l2_addr", LW'(l2_mem_address), '0);
    chk_v("rst_l2_wdata", l2_mem_wdata, '0);
    chk_b("rst_i_resp", i_mem_resp, 1'b0);
    chk_b("rst_d_resp", d_mem_resp, 1'b0);
    chk_v("rst_i_rdata", i_mem_rdata, '0);
    chk_v("rst_d_rdata", d_mem_rdata, '0);

    // single I read with 5-cycle L2 latency
    do_reset();
    l2_lat = 5;
    fork
      txn(1'b0, 1'b0, 32'h100, '0, 0);
      begin
        @(negedge clk);
        chk_b("t1_c0_l2_read", l2_mem_read, 1'b0);
        @(negedge clk);
        chk_b("t1_c1_l2_read", l2_mem_read, 1'b1);
        chk_v("t1_c1_l2_addr", LW'(l2_mem_address), LW'(32'h100));
        repeat (3) @(negedge clk);
        chk_b("t1_c4_i_resp", i_mem_resp, 1'b0);
        @(negedge clk);
        chk_b("t1_c5_i_resp", i_mem_resp, 1'b1);
        chk_v("t1_c5_i_rdata", i_mem_rdata, {32{8'hA5}});
        chk_b("t1_c5_d_resp", d_mem_resp, 1'b0);
        @(negedge clk);
        chk_b("t1_c6_l2_read", l2_mem_read, 1'b0);
      end
    join

    // simultaneous I read and D write after reset
    do_reset();
    l2_lat = 3;
    glog.delete();
    wd = {8{32'hC0DE_0000 | 32'($urandom_range(0, 65535))}};
    fork
      txn(1'b0, 1'b0, 32'h100, '0, 0);
      txn(1'b1, 1'b1, 32'h200, wd, 0);
    join
    chk_v("sim_grants", LW'(glog.size()), LW'(2));
    if (glog.size() == 2) begin
      chk_b("sim_first_i", glog[0].owner_d, 1'b0);
      chk_b("sim_second_d", glog[1].owner_d, 1'b1);
      chk_v("sim_d_addr", LW'(glog[1].addr), LW'(32'h200));
      chk_b("sim_d_write", glog[1].wr, 1'b1);
      chk_v("sim_d_wdata", glog[1].wdata, wd);
      chk_v("sim_gap", LW'(glog[1].gap), LW'(2));
    end

    // continuous contention: strict alternation with one idle cycle between grants
    do_reset();
    glog.delete();
    fork
      for (int k = 0; k < 3; k++) txn(1'b0, 1'b0, AW'(32'h100 + 32 * k), '0, 0);
      for (int k = 0; k < 3; k++) txn(1'b1, 1'b1, AW'(32'h200 + 32 * k), {8{$urandom}}, 0);
    join
    chk_v("cont_grants", LW'(glog.size()), LW'(6));
    if (glog.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk_b($sformatf("cont_order%0d", k), glog[k].owner_d, 1'(k % 2));
        if (k > 0) chk_v($sformatf("cont_gap%0d", k), LW'(glog[k].gap), LW'(2));
      end
    end

    // aborts leave priority unchanged
    abort_then_tie(1'b1);
    abort_then_tie(1'b0);

    // isolation of the non-granted requester
    do_reset();
    l2_lat = 6;
    wd = {8{$urandom}};
    fork
      txn(1'b0, 1'b1, 32'h140, wd, 0);
      for (int k = 1; k <= 5; k++) begin
        @(posedge clk);
        #1;
        d_mem_address = $urandom;
        d_mem_wdata = {8{$urandom}};
        @(negedge clk);
        chk_v($sformatf("iso_addr%0d", k), LW'(l2_mem_address), LW'(32'h140));
        chk_v($sformatf("iso_wdata%0d", k), l2_mem_wdata, wd);
        chk_v($sformatf("iso_d_rdata%0d", k), d_mem_rdata, '0);
      end
    join
    d_mem_address = '0;
    d_mem_wdata = '0;

    // asynchronous reset during SERVE_D, then a stray L2 response
    do_reset();
    l2_lat = 10;
    d_mem_read = 1'b1;
    d_mem_address = 32'h220;
    repeat (2) @(negedge clk);
    chk_b("rstm_granted", l2_mem_read, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_b("rstm_l2_read", l2_mem_read, 1'b0);
    chk_v("rstm_l2_addr", LW'(l2_mem_address), '0);
    chk_v("rstm_d_rdata", d_mem_rdata, '0);
    chk_b("rstm_d_resp", d_mem_resp, 1'b0);
    d_mem_read = 1'b0;
    d_mem_address = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    l2_auto = 1'b0;
    manual_resp = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_b("rstm_stray_i_resp", i_mem_resp, 1'b0);
      chk_b("rstm_stray_d_resp", d_mem_resp, 1'b0);
    end
    manual_resp = 1'b0;
    @(posedge clk);
    #3 l2_auto = 1'b1;

    // randomized traffic on disjoint address windows
    do_reset();
    l2_lat_rand = 1'b1;
    fork
      for (int k = 0; k < 30; k++) begin
        txn(1'b0, 1'($urandom_range(0, 1)), AW'(32'h1000 + 32 * $urandom_range(0, 7)), {8{$urandom}}, 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      for (int k = 0; k < 30; k++) begin
        txn(1'b1, 1'($urandom_range(0, 1)), AW'(32'h1200 + 32 * $urandom_range(0, 7)), {8{$urandom}}, 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    join
    repeat (3) @(negedge clk);
    chk_v("sb_drain", LW'(qi.size() + qd.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
